// File: rtl/chan_pkt_ram.sv
// Per-channel TX packet buffer: the USB packet writer fills fixed-size slots,
// the channel FIFO reader drains them through a show-ahead read word.
module chan_pkt_ram #(
  parameter int NUM_PKTS_LOG2  = 2,
  parameter int PKT_WORDS_LOG2 = 7
) (
  input  logic                     tx_clock,
  input  logic                     reset,
  input  logic [31:0]              datain,
  input  logic                     wrreq,
  input  logic                     wr_done,
  output logic                     have_space,
  output logic [31:0]              fifodata,
  output logic                     pkt_waiting,
  input  logic                     rdreq,
  input  logic                     skip,
  output logic                     overrun,
  output logic [NUM_PKTS_LOG2:0]   pkt_count
);

  localparam int ADDR_W = NUM_PKTS_LOG2 + PKT_WORDS_LOG2;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam logic [NUM_PKTS_LOG2:0] PKT_CAP = (NUM_PKTS_LOG2 + 1)'(1 << NUM_PKTS_LOG2);

  logic [31:0] mem [0:DEPTH-1];

  logic [NUM_PKTS_LOG2-1:0]  wr_slot_reg, wr_slot_next;
  logic [PKT_WORDS_LOG2:0]   wr_word_reg, wr_word_next;   // one extra bit: saturates at slot end
  logic [NUM_PKTS_LOG2-1:0]  rd_slot_reg, rd_slot_next;
  logic [PKT_WORDS_LOG2-1:0] rd_word_reg, rd_word_next;
  logic [NUM_PKTS_LOG2:0]    pkt_count_reg, pkt_count_next;
  logic                      overrun_reg, overrun_next;
  logic [31:0]               rd_data_reg;

  logic                      wr_full, wr_en, wr_drop, commit, pkt_avail, rel_pkt, rd_adv, bypass;
  logic [PKT_WORDS_LOG2:0]   wr_word_inc;
  logic [ADDR_W-1:0]         wr_addr, rd_addr_next;

  // Pointer and counter next-state; a word written alongside wr_done belongs to the committed packet
  always_comb begin
    have_space     = pkt_count_reg < PKT_CAP;
    wr_full        = wr_word_reg[PKT_WORDS_LOG2];
    wr_en          = wrreq & have_space & ~wr_full & ~reset;
    wr_drop        = wrreq & ~(have_space & ~wr_full);
    wr_word_inc    = wr_word_reg + {{PKT_WORDS_LOG2{1'b0}}, wr_en};
    commit         = wr_done & (wr_word_inc != '0);
    pkt_avail      = pkt_count_reg != '0;
    rel_pkt        = skip & pkt_avail;
    rd_adv         = rdreq & pkt_avail & ~rel_pkt & (rd_word_reg != '1);
    // The packet being released this cycle must not be reported as waiting
    pkt_waiting    = pkt_count_reg > {{NUM_PKTS_LOG2{1'b0}}, rel_pkt};

    wr_slot_next   = wr_slot_reg + {{(NUM_PKTS_LOG2-1){1'b0}}, commit};
    wr_word_next   = commit ? '0 : wr_word_inc;
    rd_slot_next   = rd_slot_reg + {{(NUM_PKTS_LOG2-1){1'b0}}, rel_pkt};
    rd_word_next   = rel_pkt ? '0 : rd_word_reg + {{(PKT_WORDS_LOG2-1){1'b0}}, rd_adv};
    pkt_count_next = pkt_count_reg + {{NUM_PKTS_LOG2{1'b0}}, commit}
                                   - {{NUM_PKTS_LOG2{1'b0}}, rel_pkt};
    overrun_next   = overrun_reg | wr_drop;

    wr_addr        = {wr_slot_reg, wr_word_reg[PKT_WORDS_LOG2-1:0]};
    rd_addr_next   = {rd_slot_next, rd_word_next};
    // Forward a word written to the address about to be shown (single-word commit case)
    bypass         = wr_en & (wr_addr == rd_addr_next);
  end

  // Pointer, counter and sticky overrun registers
  always_ff @(posedge tx_clock) begin
    if (reset) begin
      wr_slot_reg   <= '0;
      wr_word_reg   <= '0;
      rd_slot_reg   <= '0;
      rd_word_reg   <= '0;
      pkt_count_reg <= '0;
      overrun_reg   <= 1'b0;
    end else begin
      wr_slot_reg   <= wr_slot_next;
      wr_word_reg   <= wr_word_next;
      rd_slot_reg   <= rd_slot_next;
      rd_word_reg   <= rd_word_next;
      pkt_count_reg <= pkt_count_next;
      overrun_reg   <= overrun_next;
    end
  end

  // RAM write port
  always_ff @(posedge tx_clock) begin
    if (wr_en) mem[wr_addr] <= datain;
  end

  // RAM read port addressed with the next read position so fifodata never bubbles
  always_ff @(posedge tx_clock) begin
    if (reset)       rd_data_reg <= '0;
    else if (bypass) rd_data_reg <= datain;
    else             rd_data_reg <= mem[rd_addr_next];
  end

  assign fifodata  = rd_data_reg;
  assign overrun   = overrun_reg;
  assign pkt_count = pkt_count_reg;

endmodule

// File: tb/tb_chan_pkt_ram.sv
// Scoreboard bench for chan_pkt_ram: expected read words are queued when
// the read is requested and compared when the word reaches fifodata.
module tb_chan_pkt_ram;

  logic        tx_clock = 1'b0;
  logic        reset, wrreq, wr_done, rdreq, skip;
  logic [31:0] datain, fifodata;
  logic        have_space, pkt_waiting, overrun;
  logic [2:0]  pkt_count;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] want;

  chan_pkt_ram #(.NUM_PKTS_LOG2(2), .PKT_WORDS_LOG2(7)) dut (
    .tx_clock(tx_clock), .reset(reset), .datain(datain), .wrreq(wrreq),
    .wr_done(wr_done), .have_space(have_space), .fifodata(fifodata),
    .pkt_waiting(pkt_waiting), .rdreq(rdreq), .skip(skip),
    .overrun(overrun), .pkt_count(pkt_count)
  );

  always #5 tx_clock = ~tx_clock;

  task automatic cyc();
    @(posedge tx_clock);
    #1;
  endtask

  task automatic idle();
    wrreq = 0; wr_done = 0; rdreq = 0; skip = 0; datain = '0; reset = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    cyc();
    reset = 0;
  endtask

  task automatic write_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      datain = base + 32'(i);
      wrreq  = 1;
      cyc();
    end
    wrreq = 0;
  endtask

  task automatic commit_pkt();
    wr_done = 1;
    cyc();
    wr_done = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (have_space !== 1'b1) begin errors++; $display("FAIL rst_have_space got %b want 1", have_space); end
    checks++; if (pkt_waiting !== 1'b0) begin errors++; $display("FAIL rst_pkt_waiting got %b want 0", pkt_waiting); end
    checks++; if (pkt_count !== 3'd0) begin errors++; $display("FAIL rst_pkt_count got %0d want 0", pkt_count); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun got %b want 0", overrun); end
    checks++; if (fifodata !== 32'h0) begin errors++; $display("FAIL rst_fifodata got %h want 0", fifodata); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    do_reset();
    write_words(32'hA000_0000, 4);
    exp_q.push_back(32'hA000_0000);
    commit_pkt();
    checks++; if (pkt_count !== 3'd1) begin errors++; $display("FAIL basic_count got %0d want 1", pkt_count); end
    checks++; if (pkt_waiting !== 1'b1) begin errors++; $display("FAIL basic_waiting got %b want 1", pkt_waiting); end
    want = exp_q.pop_front();
    checks++; if (fifodata !== want) begin errors++; $display("FAIL basic_hdr got %h want %h", fifodata, want); end
    for (int i = 1; i <= 2; i++) begin
      rdreq = 1;
      exp_q.push_back(32'hA000_0000 + 32'(i));
      cyc();
      want = exp_q.pop_front();
      checks++; if (fifodata !== want) begin errors++; $display("FAIL basic_rd got %h want %h", fifodata, want); end
      $display("rd basic word %0d = %h", i, fifodata);
    end
    rdreq = 0;
  endtask

  task automatic test_skip_last();
    skip = 1;
    #1;
    checks++; if (pkt_waiting !== 1'b0) begin errors++; $display("FAIL skip_waiting_same got %b want 0", pkt_waiting); end
    cyc();
    skip = 0;
    checks++; if (pkt_waiting !== 1'b0) begin errors++; $display("FAIL skip_waiting_after got %b want 0", pkt_waiting); end
    checks++; if (pkt_count !== 3'd0) begin errors++; $display("FAIL skip_count got %0d want 0", pkt_count); end
    $display("test_skip_last done");
  endtask

  task automatic test_full();
    do_reset();
    for (int p = 0; p < 4; p++) begin
      write_words(32'hB000_0000 | (32'(p) << 8), 128);
      commit_pkt();
    end
    checks++; if (have_space !== 1'b0) begin errors++; $display("FAIL full_have_space got %b want 0", have_space); end
    checks++; if (pkt_count !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", pkt_count); end
    datain = 32'hDEAD_BEEF; wrreq = 1;
    cyc();
    wrreq = 0;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL full_overrun got %b want 1", overrun); end
    checks++; if (pkt_count !== 3'd4) begin errors++; $display("FAIL full_count2 got %0d want 4", pkt_count); end
    exp_q.push_back(32'hB000_0000);
    cyc();
    want = exp_q.pop_front();
    checks++; if (fifodata !== want) begin errors++; $display("FAIL full_mem_intact got %h want %h", fifodata, want); end
    skip = 1;
    exp_q.push_back(32'hB000_0100);
    cyc();
    skip = 0;
    checks++; if (have_space !== 1'b1) begin errors++; $display("FAIL full_space_after_skip got %b want 1", have_space); end
    checks++; if (pkt_count !== 3'd3) begin errors++; $display("FAIL full_count3 got %0d want 3", pkt_count); end
    want = exp_q.pop_front();
    checks++; if (fifodata !== want) begin errors++; $display("FAIL full_next_hdr got %h want %h", fifodata, want); end
    for (int i = 1; i <= 2; i++) begin
      rdreq = 1;
      exp_q.push_back(32'hB000_0100 + 32'(i));
      cyc();
      want = exp_q.pop_front();
      checks++; if (fifodata !== want) begin errors++; $display("FAIL full_rd got %h want %h", fifodata, want); end
      $display("rd full word %0d = %h", i, fifodata);
    end
    rdreq = 0;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL full_overrun_sticky got %b want 1", overrun); end
  endtask

  task automatic test_simul();
    do_reset();
    write_words(32'hC000_0000, 4); commit_pkt();
    write_words(32'hC100_0000, 4); commit_pkt();
    write_words(32'hC200_0000, 4);
    wr_done = 1; skip = 1;
    exp_q.push_back(32'hC100_0000);
    cyc();
    wr_done = 0; skip = 0;
    checks++; if (pkt_count !== 3'd2) begin errors++; $display("FAIL simul_count got %0d want 2", pkt_count); end
    want = exp_q.pop_front();
    checks++; if (fifodata !== want) begin errors++; $display("FAIL simul_hdr got %h want %h", fifodata, want); end
    for (int i = 1; i <= 3; i++) begin
      rdreq = 1;
      exp_q.push_back(32'hC100_0000 + 32'(i));
      cyc();
      want = exp_q.pop_front();
      checks++; if (fifodata !== want) begin errors++; $display("FAIL simul_rd got %h want %h", fifodata, want); end
      $display("rd simul word %0d = %h", i, fifodata);
    end
    rdreq = 0;
    skip = 1;
    exp_q.push_back(32'hC200_0000);
    cyc();
    skip = 0;
    want = exp_q.pop_front();
    checks++; if (fifodata !== want) begin errors++; $display("FAIL simul_slot2_hdr got %h want %h", fifodata, want); end
    checks++; if (pkt_count !== 3'd1) begin errors++; $display("FAIL simul_count2 got %0d want 1", pkt_count); end
  endtask

  task automatic test_overflow();
    do_reset();
    write_words(32'h5000_0000, 129);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovf_overrun got %b want 1", overrun); end
    exp_q.push_back(32'h5000_0000);
    commit_pkt();
    checks++; if (pkt_count !== 3'd1) begin errors++; $display("FAIL ovf_count got %0d want 1", pkt_count); end
    want = exp_q.pop_front();
    checks++; if (fifodata !== want) begin errors++; $display("FAIL ovf_hdr got %h want %h", fifodata, want); end
    for (int i = 1; i <= 130; i++) begin
      rdreq = 1;
      exp_q.push_back(32'h5000_0000 + 32'((i > 127) ? 127 : i));
      cyc();
      want = exp_q.pop_front();
      checks++; if (fifodata !== want) begin errors++; $display("FAIL ovf_rd got %h want %h", fifodata, want); end
      $display("rd ovf word %0d = %h", i, fifodata);
    end
    rdreq = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    write_words(32'hD000_0000, 129);
    commit_pkt();
    write_words(32'hD100_0000, 50);
    for (int i = 1; i <= 10; i++) begin
      rdreq = 1;
      exp_q.push_back(32'hD000_0000 + 32'(i));
      cyc();
      want = exp_q.pop_front();
      checks++; if (fifodata !== want) begin errors++; $display("FAIL rmid_rd got %h want %h", fifodata, want); end
      $display("rd rmid word %0d = %h", i, fifodata);
    end
    rdreq = 0;
    reset = 1;
    cyc();
    reset = 0;
    checks++; if (pkt_count !== 3'd0) begin errors++; $display("FAIL rmid_count got %0d want 0", pkt_count); end
    checks++; if (pkt_waiting !== 1'b0) begin errors++; $display("FAIL rmid_waiting got %b want 0", pkt_waiting); end
    checks++; if (have_space !== 1'b1) begin errors++; $display("FAIL rmid_space got %b want 1", have_space); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rmid_overrun got %b want 0", overrun); end
    checks++; if (fifodata !== 32'h0) begin errors++; $display("FAIL rmid_fifodata got %h want 0", fifodata); end
    write_words(32'hE000_0000, 4);
    exp_q.push_back(32'hE000_0000);
    commit_pkt();
    checks++; if (pkt_count !== 3'd1) begin errors++; $display("FAIL rmid_count2 got %0d want 1", pkt_count); end
    want = exp_q.pop_front();
    checks++; if (fifodata !== want) begin errors++; $display("FAIL rmid_hdr got %h want %h", fifodata, want); end
    for (int i = 1; i <= 3; i++) begin
      rdreq = 1;
      exp_q.push_back(32'hE000_0000 + 32'(i));
      cyc();
      want = exp_q.pop_front();
      checks++; if (fifodata !== want) begin errors++; $display("FAIL rmid_rd2 got %h want %h", fifodata, want); end
      $display("rd rmid2 word %0d = %h", i, fifodata);
    end
    rdreq = 0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    datain = 32'hF0F0_0001; wrreq = 1; wr_done = 1;
    exp_q.push_back(32'hF0F0_0001);
    cyc();
    wrreq = 0; wr_done = 0;
    checks++; if (pkt_count !== 3'd1) begin errors++; $display("FAIL b2b_count got %0d want 1", pkt_count); end
    checks++; if (pkt_waiting !== 1'b1) begin errors++; $display("FAIL b2b_waiting got %b want 1", pkt_waiting); end
    want = exp_q.pop_front();
    checks++; if (fifodata !== want) begin errors++; $display("FAIL b2b_hdr got %h want %h", fifodata, want); end
    write_words(32'hF1F1_0000, 2);
    wr_done = 1; skip = 1;
    exp_q.push_back(32'hF1F1_0000);
    cyc();
    wr_done = 0; skip = 0;
    want = exp_q.pop_front();
    checks++; if (fifodata !== want) begin errors++; $display("FAIL b2b_next_hdr got %h want %h", fifodata, want); end
    checks++; if (pkt_count !== 3'd1) begin errors++; $display("FAIL b2b_count2 got %0d want 1", pkt_count); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 1;
    test_reset();
    test_basic();
    test_skip_last();
    test_full();
    test_simul();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chan_pkt_ram.md
Name: chan_pkt_ram

Overview:
- Per-channel TX packet buffer between the USB packet writer (upstream) and the channel FIFO reader (downstream).
- Stores whole 128-word (512-byte) packets in fixed slots.
- Exposes a zero-latency show-ahead read word, a packet-available flag, per-word read acknowledge, and a skip that discards the rest of the current packet.
- Single clock domain: tx_clock.

Parameters:
- NUM_PKTS_LOG2, 2, log2 of the number of packet slots (default 4 slots).
- PKT_WORDS_LOG2, 7, log2 of words per slot (128 x 32-bit).

Ports:
- tx_clock  input  1  clock for all logic.
- reset  input  1  synchronous, active-high reset.
- datain  input  32  write word from the packet writer.
- wrreq  input  1  write datain at the current write position.
- wr_done  input  1  one-cycle pulse after the last word; commits the packet being written.
- have_space  output  1  the slot under write is free.
- fifodata  output  32  word at the current read position, valid in the same cycle.
- pkt_waiting  output  1  at least one committed packet is available to the reader.
- rdreq  input  1  acknowledge fifodata; advance the read position.
- skip  input  1  one-cycle pulse; release the current read packet.
- overrun  output  1  sticky: a write arrived with no space, or past the slot end.
- pkt_count  output  NUM_PKTS_LOG2+1  number of committed, unreleased packets.

Behaviour:
- Storage: 2^(NUM_PKTS_LOG2+PKT_WORDS_LOG2) x 32 RAM. Address = {slot, word}.
- Write side:
  - wrreq with have_space=1 writes datain at {wr_slot, wr_word}, then wr_word increments.
  - wr_word saturates at 2^PKT_WORDS_LOG2. A write at the saturated value is dropped and sets overrun.
  - wrreq with have_space=0 is dropped and sets overrun.
  - wr_done with wr_word>0 commits: wr_slot increments (wraps modulo slots), wr_word clears to 0, pkt_count increments.
  - wr_done with wr_word=0 is ignored.
  - wrreq and wr_done in the same cycle: the word is written first and counts toward the committed packet.
  - have_space = (pkt_count < 2^NUM_PKTS_LOG2), combinational from registers.
- Read side:
  - fifodata always equals mem[{rd_slot, rd_word}] in the current cycle. Implement as a registered read of the next address so there are no bubbles.
  - rdreq=1 with pkt_count>0 increments rd_word (saturates at 2^PKT_WORDS_LOG2-1). fifodata shows the next word in the following cycle.
  - rdreq with pkt_count=0 is ignored; fifodata is then don't-care.
  - skip=1: rd_slot increments (wraps), rd_word clears to 0, pkt_count decrements. skip has priority over a simultaneous rdreq.
  - skip with pkt_count=0 is ignored.
- pkt_waiting = (pkt_count - skip) > 0, evaluated combinationally.
  - The reader samples pkt_waiting in the same cycle it pulses skip, so the packet being released must not count.
  - Skip releasing the last packet therefore forces pkt_waiting=0 in that cycle.
- Commit and release in the same cycle: pkt_count unchanged, both slot pointers advance.
- A commit while the reader is mid-packet in another slot does not disturb rd_word or fifodata.
- Bypass: a write to the address currently being read is not required to appear on fifodata. The reader never reads an uncommitted slot.
- Read latency: header word is visible on fifodata in the same cycle pkt_waiting first rises. Each rdreq cycle exposes the next word one cycle later.
- Reset (synchronous; also when asserted mid-packet on either side):
  - Clears wr_slot, wr_word, rd_slot, rd_word, pkt_count and overrun.
  - Outputs: have_space=1, pkt_waiting=0, pkt_count=0, overrun=0, fifodata=0.
  - Partially written packets are discarded.
- overrun clears only on reset.

Test Plan:
- Write 4 words (0xA0000000..0xA0000003), pulse wr_done -> next cycle pkt_count=1, pkt_waiting=1, fifodata=0xA0000000. rdreq high 2 cycles -> fifodata 0xA0000001 then 0xA0000002.
- Commit 4 packets of 128 words -> have_space=0. A 5th wrreq -> overrun=1, memory unchanged. One skip -> have_space=1 next cycle, fifodata shows word 0 of packet 2.
- One packet committed, reader pulses skip -> pkt_waiting=0 in the skip cycle and after, pkt_count=0.
- wr_done and skip in the same cycle with pkt_count=2 -> pkt_count stays 2, rd_slot=1, wr_slot advanced; data in slot 1 intact.
- Write 129 words into one slot -> 129th dropped, overrun=1. wr_done commits 128 words; rdreq saturates at word 127.
- Reset asserted after 50 words written and reader at word 10 -> next cycle pkt_count=0, pkt_waiting=0, have_space=1, overrun=0. The following packet is read correctly from slot 0.
